// File: rtl/pll_lock_sequencer.sv
// PLL lock consumer: synchronizes `locked`, holds sys_reset until lock is stable,
// filters short lock glitches, counts lock losses and restarts a PLL that never locks.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int GLITCH_FILTER  = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int PLLRST_CYCLES  = 16
) (
    input  logic       clk_pix,
    input  logic       reset,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lock_lost_count,
    output logic [2:0] state
);

    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_STABLE = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_PLLRST = 3'd3;

    localparam int SW = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int GW = (GLITCH_FILTER  > 1) ? $clog2(GLITCH_FILTER)  : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PW = (PLLRST_CYCLES  > 1) ? $clog2(PLLRST_CYCLES)  : 1;

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_FILTER - 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PRST_LAST   = PW'(PLLRST_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;

    logic [2:0]    state_nx;
    logic [SW-1:0] stable_cnt, stable_nx;
    logic [GW-1:0] glitch_cnt, glitch_nx;
    logic [TW-1:0] timer,      timer_nx;
    logic [PW-1:0] prst_cnt,   prst_nx;
    logic [7:0]    lost_nx;

    assign locked_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk_pix) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], locked};
    end

    always_comb begin
        state_nx  = state;
        stable_nx = stable_cnt;
        glitch_nx = glitch_cnt;
        timer_nx  = timer;
        prst_nx   = prst_cnt;
        lost_nx   = lock_lost_count;
        case (state)
            ST_WAIT: begin
                if (locked_s) begin
                    state_nx  = ST_STABLE;
                    stable_nx = '0;
                    timer_nx  = '0;
                end else if (TIMEOUT_CYCLES != 0 && timer == TIMER_LAST) begin
                    state_nx = ST_PLLRST;
                    timer_nx = '0;
                    prst_nx  = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_nx  = ST_WAIT;
                    stable_nx = '0;
                    timer_nx  = '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_nx  = ST_RUN;
                    stable_nx = '0;
                    glitch_nx = '0;
                end else begin
                    stable_nx = stable_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss is declared on the cycle the low run would reach GLITCH_FILTER.
                if (locked_s) begin
                    glitch_nx = '0;
                end else if (glitch_cnt == GLITCH_LAST) begin
                    state_nx  = ST_WAIT;
                    glitch_nx = '0;
                    timer_nx  = '0;
                    if (lock_lost_count != 8'hFF) lost_nx = lock_lost_count + 8'd1;
                end else begin
                    glitch_nx = glitch_cnt + 1'b1;
                end
            end
            ST_PLLRST: begin
                if (prst_cnt == PRST_LAST) begin
                    state_nx = ST_WAIT;
                    prst_nx  = '0;
                    timer_nx = '0;
                end else begin
                    prst_nx = prst_cnt + 1'b1;
                end
            end
            default: state_nx = ST_WAIT;
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as `state`.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state           <= ST_WAIT;
            stable_cnt      <= '0;
            glitch_cnt      <= '0;
            timer           <= '0;
            prst_cnt        <= '0;
            lock_lost_count <= '0;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            pll_rst         <= 1'b0;
        end else begin
            state           <= state_nx;
            stable_cnt      <= stable_nx;
            glitch_cnt      <= glitch_nx;
            timer           <= timer_nx;
            prst_cnt        <= prst_nx;
            lock_lost_count <= lost_nx;
            sys_reset       <= (state_nx != ST_RUN);
            ready           <= (state_nx == ST_RUN);
            pll_rst         <= (state_nx == ST_PLLRST);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboarded bench for pll_lock_sequencer: a run-length reference model predicts the
// outputs after every edge, a monitor compares them; directed checks cover the key timings.
module tb_pll_lock_sequencer;

    localparam int SYNC    = 2;
    localparam int STABLE  = 16;
    localparam int GLITCH  = 4;
    localparam int TIMEOUT = 100;
    localparam int PRSTLEN = 16;

    logic       clk_pix = 1'b0;
    logic       reset   = 1'b1;
    logic       locked  = 1'b0;
    logic       pll_rst, sys_reset, ready;
    logic [7:0] lock_lost_count;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    pll_lock_sequencer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .GLITCH_FILTER (GLITCH),
        .TIMEOUT_CYCLES(TIMEOUT),
        .PLLRST_CYCLES (PRSTLEN)
    ) dut (
        .clk_pix        (clk_pix),
        .reset          (reset),
        .locked         (locked),
        .pll_rst        (pll_rst),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .lock_lost_count(lock_lost_count),
        .state          (state)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int st;
        int srst;
        int rdy;
        int prst;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: phase number plus run lengths of what the phase has seen so far.
    bit q_ls[$];
    int ph, waited, stable_seen, low_run, prst_seen, lost;

    task automatic model_edge(input logic r, input logic l);
        bit   ls;
        exp_t e;
        if (r) begin
            q_ls = {};
            for (int i = 0; i < SYNC; i++) q_ls.push_back(1'b0);
            ph = 0; waited = 0; stable_seen = 0; low_run = 0; prst_seen = 0; lost = 0;
        end else begin
            ls = q_ls.pop_front();
            q_ls.push_back(l);
            case (ph)
                0: if (ls) begin
                       ph = 1; stable_seen = 0;
                   end else begin
                       waited++;
                       if (TIMEOUT != 0 && waited == TIMEOUT) begin ph = 3; prst_seen = 0; end
                   end
                1: if (!ls) begin
                       ph = 0; waited = 0;
                   end else begin
                       stable_seen++;
                       if (stable_seen == STABLE) begin ph = 2; low_run = 0; end
                   end
                2: if (ls) low_run = 0;
                   else begin
                       low_run++;
                       if (low_run == GLITCH) begin
                           ph = 0; waited = 0;
                           lost = (lost < 255) ? lost + 1 : 255;
                       end
                   end
                default: begin
                       prst_seen++;
                       if (prst_seen == PRSTLEN) begin ph = 0; waited = 0; end
                   end
            endcase
        end
        e.st = ph; e.srst = (ph != 2); e.rdy = (ph == 2); e.prst = (ph == 3); e.cnt = lost;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic l);
        @(negedge clk_pix);
        reset  = r;
        locked = l;
        model_edge(r, l);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic after_edge();
        @(posedge clk_pix);
        #2;
    endtask

    // Monitor: every edge that has a prediction pending is compared against the DUT.
    always @(posedge clk_pix) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(state) != e.st || int'(sys_reset) != e.srst || int'(ready) != e.rdy ||
                int'(pll_rst) != e.prst || int'(lock_lost_count) != e.cnt) begin
                failures++;
                $display("FAIL sb @%0t: actual st=%0d srst=%0d rdy=%0d prst=%0d cnt=%0d required st=%0d srst=%0d rdy=%0d prst=%0d cnt=%0d",
                         $time, state, sys_reset, ready, pll_rst, lock_lost_count,
                         e.st, e.srst, e.rdy, e.prst, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises[$];
        int hi_cnt;
        logic prev_p;

        // Reset 3 cycles with lock already high; RUN must arrive at edge 3+STABLE.
        repeat (3) step(1'b1, 1'b1);
        after_edge();
        chk("reset_sys_reset", int'(sys_reset), 1);
        chk("reset_ready", int'(ready), 0);
        chk("reset_pll_rst", int'(pll_rst), 0);
        chk("reset_count", int'(lock_lost_count), 0);
        for (int i = 1; i <= 25; i++) begin
            step(1'b0, 1'b1);
            after_edge();
            if (i == 2)  chk("edge2_state", int'(state), 0);
            if (i == 3)  chk("edge3_state", int'(state), 1);
            if (i == 18) chk("edge18_ready", int'(ready), 0);
            if (i == 19) chk("edge19_state", int'(state), 2);
            if (i == 19) chk("edge19_sys_reset", int'(sys_reset), 0);
        end

        // 3-cycle glitch is filtered; 4-cycle glitch is a lock loss.
        repeat (3) step(1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1);
        after_edge();
        chk("glitch3_ready", int'(ready), 1);
        chk("glitch3_count", int'(lock_lost_count), 0);
        repeat (4) step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1);
        after_edge();
        chk("glitch4_sys_reset", int'(sys_reset), 1);
        chk("glitch4_count", int'(lock_lost_count), 1);

        // Drop lock after about 10 STABLE cycles, then a fresh qualification.
        repeat (30) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        repeat (13) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b1);

        // Randomized lock behaviour, including long unlocked runs that hit the timeout.
        for (int seg = 0; seg < 120; seg++) begin
            int kind = $urandom_range(0, 9);
            int len;
            logic lv;
            if (kind < 4)      begin lv = 1'b1; len = $urandom_range(5, 40); end
            else if (kind < 8) begin lv = 1'b0; len = $urandom_range(1, 6); end
            else               begin lv = 1'b0; len = $urandom_range(60, 260); end
            for (int k = 0; k < len; k++) step(($urandom_range(0, 499) == 0), lv);
        end

        // Never locked: pll_rst pulses PRSTLEN wide, one per TIMEOUT+PRSTLEN cycles.
        repeat (2) step(1'b1, 1'b0);
        hi_cnt = 0;
        prev_p = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            step(1'b0, 1'b0);
            after_edge();
            if (pll_rst) hi_cnt++;
            if (pll_rst && !prev_p) rises.push_back(i);
            prev_p = pll_rst;
        end
        chk("pllrst_pulses", rises.size(), 2);
        chk("pllrst_high_cycles", hi_cnt, 2 * PRSTLEN);
        if (rises.size() == 2) chk("pllrst_period", rises[1] - rises[0], TIMEOUT + PRSTLEN);

        // 300 lock-loss events saturate the counter; reset in RUN clears everything.
        repeat (2) step(1'b1, 1'b1);
        for (int n = 0; n < 300; n++) begin
            repeat (22) step(1'b0, 1'b1);
            repeat (5) step(1'b0, 1'b0);
        end
        after_edge();
        chk("saturated_count", int'(lock_lost_count), 255);
        repeat (22) step(1'b0, 1'b1);
        after_edge();
        chk("run_before_reset", int'(ready), 1);
        step(1'b1, 1'b1);
        after_edge();
        chk("reset_in_run_state", int'(state), 0);
        chk("reset_in_run_sys_reset", int'(sys_reset), 1);
        chk("reset_in_run_count", int'(lock_lost_count), 0);
        step(1'b0, 1'b1);

        repeat (3) after_edge();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
